inst_assembler: RTL
===================

// Module: inst_assembler
// PURPOSE
//  Inverse of the instruction decoder: takes structured instruction commands
//  (kind, funct3, alt bit, rd/rs1/rs2, 32-bit immediate) over a valid/ready handshake.
//  Encodes each command into an RV32I word (miniRV subset: R, I, LOAD, S, B, LUI, JAL, JALR).
//  Writes the word sequentially into instruction memory.
//  Used by the trace/self-test harness to build programs in IROM without an external toolchain.
// PARAMETERS
//  AW    10  IROM word-address width
//  DEPTH 1024  words available from base; overflow limit (<= 2**AW)
// PORTS
//  cpu_clk    in   1   clock; everything on the rising edge
//  cpu_rst    in   1   reset, synchronous, active-high
//  start      in   1   pulse: latch base_addr, clear counters, enter RUN
//  base_addr  in   AW  first IROM word address
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   block accepts a command this cycle
//  cmd_last   in   1   qualifies with cmd_valid: final command of the program
//  cmd_kind   in   3   0 R, 1 I, 2 LOAD, 3 S, 4 B, 5 LUI, 6 JAL, 7 JALR
//  cmd_funct3 in   3   funct3 (forced 010 for LOAD/S, 000 for JALR)
//  cmd_alt    in   1   funct7[5]: SUB/SRA (R), SRAI (I shift)
//  cmd_rd     in   5   destination register
//  cmd_rs1    in   5   source register 1
//  cmd_rs2    in   5   source register 2
//  cmd_imm    in   32  signed immediate / byte offset (LUI: full value, low 12 bits 0)
//  wr_en      out  1   IROM write strobe
//  wr_addr    out  AW  IROM word address
//  wr_data    out  32  encoded instruction word
//  busy       out  1   state != IDLE
//  done       out  1   one-cycle pulse on entry to DONE
//  overflow   out  1   sticky: command arrived with DEPTH words already written
//  err        out  1   sticky: at least one illegal command dropped
//  wr_count   out  AW+1  words written since start
// BEHAVIOUR
//  Reset: state IDLE; every output 0; counters 0; sticky flags cleared.
//  FSM IDLE -> RUN on start.
//  FSM RUN -> DONE on an accepted cmd_last, or on overflow.
//  FSM DONE -> RUN on start. DONE waits there otherwise.
//  start in RUN re-latches base_addr and clears the counters (restart).
//  cmd_ready = (state==RUN) & ~overflow. Accept = cmd_valid & cmd_ready.
//  Latency 1: for a legal accept in cycle N, wr_en/wr_addr/wr_data are registered and valid in N+1.
//  Only one write per accept. wr_en is low in every other cycle.
//  Address: wr_addr = base + wr_count. Wraps modulo 2**AW; the wrap is not an error.
//  Encoding rules:
//   R:    {0,alt,00000}, rs2, rs1, f3, rd, 0110011.
//   I:    imm[11:0], rs1, f3, rd, 0010011. Shifts (f3 001/101): {0,alt,00000}, shamt[4:0].
//   LOAD: imm[11:0], rs1, 010, rd, 0000011.
//   S:    imm[11:5], rs2, rs1, 010, imm[4:0], 0100011.
//   B:    imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011.
//   LUI:  imm[31:12], rd, 0110111.
//   JAL:  imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111.
//   JALR: imm[11:0], rs1, 000, rd, 1100111.
//  Legality; an illegal command is accepted but not written:
//   - I/LOAD/S/JALR imm must fit signed 12 bits.
//   - Shifts need imm[31:5]==0.
//   - R needs f3 000 or 101 when alt=1.
//   - B needs f3 in {000,001,100,101}, imm signed 13 bits, and imm[0]==0.
//   - JAL needs imm signed 21 bits and imm[0]==0.
//   - LUI needs imm[11:0]==0.
//   - An illegal command sets err and does not advance the address.
//  Illegal cmd_last: DONE is still entered.
//  Overflow: a command presented with wr_count==DEPTH is not accepted. overflow sets and the FSM goes to DONE.
//  start together with cmd_valid: start wins and the command is not accepted that cycle.
//  cpu_rst mid-RUN: a pending wr_en is squashed in the same cycle (synchronous). All state is lost.
// STRUCTURE
//  Shared include rv_defs.vh holds:
//   - opcode localparams (OP_R .. OP_JALR)
//   - CMD_KIND codes
//   - funct3 constants
//  The decoder includes rv_defs.vh too, so opcodes stay single-sourced.
//  Sub-module inst_encode (combinational): kind/fields/imm -> {word[31:0], legal}.
//  The parent holds the FSM, the counters, and the output register stage.
// TESTING
//  1. start, base=0x010; addi x1,x0,5 -> wr_addr 0x010, wr_data 0x00500093, one cycle after accept.
//  2. add x3,x1,x2 -> 0x002081B3; sub (alt=1) -> 0x402081B3; lw x5,8(x2) -> 0x00812283;
//     sw x5,12(x2) -> 0x00512623.
//  3. beq x1,x2,imm=-4 -> 0xFE208EE3; lui x1,0x12345000 -> 0x123450B7; jal x1,8 -> 0x008000EF.
//  4. addi imm=4096, then beq imm=3, then addi x1,x0,5 -> two dropped with err=1;
//     third written at base+0, wr_count=1.
//  5. DEPTH=4, base=2**AW-2: five commands -> writes at 0x3FE, 0x3FF, 0x000, 0x001;
//     fifth sees cmd_ready low, overflow=1, done pulse.
//  6. cpu_rst asserted the cycle after an accept -> no wr_en that cycle, all outputs 0,
//     IDLE; cmd_ready low until the next start.

Source files
------------

// File: rtl/inst_assembler_pkg.sv
// Shared RV32I (miniRV) encoding constants, command payload and FSM codes
// for the instruction assembler.
package inst_assembler_pkg;

    localparam int unsigned XLEN = 32;

    // Major opcodes
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // Command kind codes
    localparam logic [2:0] KIND_R    = 3'd0;
    localparam logic [2:0] KIND_I    = 3'd1;
    localparam logic [2:0] KIND_LOAD = 3'd2;
    localparam logic [2:0] KIND_S    = 3'd3;
    localparam logic [2:0] KIND_B    = 3'd4;
    localparam logic [2:0] KIND_LUI  = 3'd5;
    localparam logic [2:0] KIND_JAL  = 3'd6;
    localparam logic [2:0] KIND_JALR = 3'd7;

    // funct3 values
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;

    // FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic [2:0]      kind;
        logic [2:0]      funct3;
        logic            alt;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
    } cmd_t;

    // True when v is representable as a signed value of the given bit width
    function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned bits);
        logic [XLEN-1:0] s;
        s = XLEN'($signed(v) >>> (bits - 1));
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/inst_assembler_encode.sv
// Combinational RV32I encoder: command fields -> instruction word plus a
// legality flag for fields that cannot be represented.
module inst_encode
    import inst_assembler_pkg::*;
(
    input  cmd_t        i_cmd,
    output logic [31:0] o_word_c,
    output logic        o_legal_c
);

    logic [2:0]  w_f3;
    logic [31:0] w_imm;
    logic        w_shift;

    assign w_f3    = i_cmd.funct3;
    assign w_imm   = i_cmd.imm;
    assign w_shift = (w_f3 == F3_SLL) || (w_f3 == F3_SRL);

    always_comb begin
        o_word_c  = '0;
        o_legal_c = 1'b0;
        case (i_cmd.kind)
            KIND_R: begin
                o_word_c  = {1'b0, i_cmd.alt, 5'b0, i_cmd.rs2, i_cmd.rs1, w_f3, i_cmd.rd, OP_R};
                o_legal_c = !i_cmd.alt || (w_f3 == F3_ADD) || (w_f3 == F3_SRL);
            end
            KIND_I: begin
                if (w_shift) begin
                    o_word_c  = {1'b0, i_cmd.alt, 5'b0, w_imm[4:0], i_cmd.rs1, w_f3, i_cmd.rd, OP_I};
                    o_legal_c = (w_imm[31:5] == '0);
                end else begin
                    o_word_c  = {w_imm[11:0], i_cmd.rs1, w_f3, i_cmd.rd, OP_I};
                    o_legal_c = fits_signed(w_imm, 12);
                end
            end
            KIND_LOAD: begin
                o_word_c  = {w_imm[11:0], i_cmd.rs1, F3_WORD, i_cmd.rd, OP_LOAD};
                o_legal_c = fits_signed(w_imm, 12);
            end
            KIND_S: begin
                o_word_c  = {w_imm[11:5], i_cmd.rs2, i_cmd.rs1, F3_WORD, w_imm[4:0], OP_S};
                o_legal_c = fits_signed(w_imm, 12);
            end
            KIND_B: begin
                o_word_c  = {w_imm[12], w_imm[10:5], i_cmd.rs2, i_cmd.rs1, w_f3,
                             w_imm[4:1], w_imm[11], OP_B};
                o_legal_c = ((w_f3 == F3_BEQ) || (w_f3 == F3_BNE) ||
                             (w_f3 == F3_BLT) || (w_f3 == F3_BGE)) &&
                            fits_signed(w_imm, 13) && !w_imm[0];
            end
            KIND_LUI: begin
                o_word_c  = {w_imm[31:12], i_cmd.rd, OP_LUI};
                o_legal_c = (w_imm[11:0] == '0);
            end
            KIND_JAL: begin
                o_word_c  = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], i_cmd.rd, OP_JAL};
                o_legal_c = fits_signed(w_imm, 21) && !w_imm[0];
            end
            KIND_JALR: begin
                o_word_c  = {w_imm[11:0], i_cmd.rs1, F3_JALR, i_cmd.rd, OP_JALR};
                o_legal_c = fits_signed(w_imm, 12);
            end
            default: begin
                o_word_c  = '0;
                o_legal_c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_assembler.sv
// Streams instruction commands into sequential IROM writes: encodes each
// accepted command and writes it one cycle later at base + wr_count.
module inst_assembler
    import inst_assembler_pkg::*;
#(
    parameter int unsigned AW    = 10,
    parameter int unsigned DEPTH = 1024
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_last,
    input  logic [2:0]    cmd_kind,
    input  logic [2:0]    cmd_funct3,
    input  logic          cmd_alt,
    input  logic [4:0]    cmd_rd,
    input  logic [4:0]    cmd_rs1,
    input  logic [4:0]    cmd_rs2,
    input  logic [31:0]   cmd_imm,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic          err,
    output logic [AW:0]   wr_count
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [AW-1:0] r_base;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_nxt;
    logic          r_ready;
    logic          r_ovf;
    logic          r_err;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [31:0]   r_wr_data;
    logic          r_busy;
    logic          r_done;

    logic          w_accept;
    logic          w_write;
    logic          w_ovf_hit;
    logic          w_ovf_nxt;
    logic          w_err_nxt;
    logic          w_ready_nxt;
    logic          w_legal;
    logic [31:0]   w_word;
    cmd_t          w_cmd;

    assign w_cmd = '{kind: cmd_kind, funct3: cmd_funct3, alt: cmd_alt, rd: cmd_rd,
                     rs1: cmd_rs1, rs2: cmd_rs2, imm: cmd_imm};

    inst_encode u_encode (
        .i_cmd     (w_cmd),
        .o_word_c  (w_word),
        .o_legal_c (w_legal)
    );

    // Next state, handshake and counter control; start always pre-empts a command
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = cmd_valid && r_ready && !start;
        w_ovf_hit   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end else if (cmd_valid && (r_count == DEPTH_C)) begin
                    w_ovf_hit   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (w_accept && cmd_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_write     = w_accept && w_legal;
        w_count_nxt = start ? '0 : (w_write ? r_count + (AW+1)'(1) : r_count);
        w_ovf_nxt   = start ? 1'b0 : (r_ovf || w_ovf_hit);
        w_err_nxt   = start ? 1'b0 : (r_err || (w_accept && !w_legal));
        w_ready_nxt = (w_state_nxt == ST_RUN) && (w_count_nxt != DEPTH_C) && !w_ovf_nxt;
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state   <= ST_IDLE;
            r_base    <= '0;
            r_count   <= '0;
            r_ready   <= 1'b0;
            r_ovf     <= 1'b0;
            r_err     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (start) r_base <= base_addr;
            r_count <= w_count_nxt;
            r_ready <= w_ready_nxt;
            r_ovf   <= w_ovf_nxt;
            r_err   <= w_err_nxt;
            r_wr_en <= w_write;
            if (w_write) begin
                r_wr_addr <= r_base + r_count[AW-1:0];
                r_wr_data <= w_word;
            end
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
        end
    end

    // A write already staged for this cycle is killed as soon as reset is seen
    assign wr_en     = r_wr_en && !cpu_rst;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overflow  = r_ovf;
    assign err       = r_err;
    assign wr_count  = r_count;

endmodule
